rs_alu: RTL and testbench

RS_ALU -- requirements
Module: rs_alu

---
 rtl/rs_alu.sv | 219 +++++++++++++++++++++
 tb/tb_rs_alu.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_alu.sv
// rtl/rs_alu.sv - ALU reservation station with operand wakeup, dispatch bypass and single issue.
// Optional RS_OLDEST_FIRST_EN selects the oldest ready entry instead of the lowest-indexed one.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module rs_alu #(
    parameter int RS_SIZE_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       dec_valid,
    input  logic [`ALU_OP_WIDTH-1:0]   dec_op,
    input  logic [`ROB_SIZE_WIDTH-1:0] dec_id,
    input  logic                       dec_has_dep1,
    input  logic                       dec_has_dep2,
    input  logic [`ROB_SIZE_WIDTH-1:0] dec_dep1,
    input  logic [`ROB_SIZE_WIDTH-1:0] dec_dep2,
    input  logic [`XLEN-1:0]           dec_val1,
    input  logic [`XLEN-1:0]           dec_val2,
    input  logic                       alu_ready,
    input  logic [`XLEN-1:0]           alu_res,
    input  logic [`ROB_SIZE_WIDTH-1:0] alu_id,
    input  logic                       lsb_ready,
    input  logic [`XLEN-1:0]           lsb_res,
    input  logic [`ROB_SIZE_WIDTH-1:0] lsb_id,
    output logic                       rs_full,
    output logic                       rs_ready,
    output logic [`ALU_OP_WIDTH-1:0]   rs_op,
    output logic [`XLEN-1:0]           rs_val1,
    output logic [`XLEN-1:0]           rs_val2,
    output logic [`ROB_SIZE_WIDTH-1:0] rs_id
);

    localparam int RS_SIZE = 1 << RS_SIZE_WIDTH;

    logic [RS_SIZE-1:0]         busy;
    logic [RS_SIZE-1:0]         pend1;
    logic [RS_SIZE-1:0]         pend2;
    logic [`ALU_OP_WIDTH-1:0]   op_q   [RS_SIZE];
    logic [`ROB_SIZE_WIDTH-1:0] id_q   [RS_SIZE];
    logic [`ROB_SIZE_WIDTH-1:0] dep1_q [RS_SIZE];
    logic [`ROB_SIZE_WIDTH-1:0] dep2_q [RS_SIZE];
    logic [`XLEN-1:0]           val1_q [RS_SIZE];
    logic [`XLEN-1:0]           val2_q [RS_SIZE];

    logic [RS_SIZE_WIDTH:0]     busy_cnt;
    logic [RS_SIZE_WIDTH-1:0]   free_idx;
    logic                       do_dispatch;
    logic [RS_SIZE-1:0]         rdy;
    logic                       sel_valid;
    logic [RS_SIZE_WIDTH-1:0]   sel_idx;
    logic [RS_SIZE-1:0]         busy_nxt;

    logic                       new_pend1;
    logic                       new_pend2;
    logic [`XLEN-1:0]           new_val1;
    logic [`XLEN-1:0]           new_val2;

    always_comb begin
        busy_cnt = '0;
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            busy_cnt = busy_cnt + {{RS_SIZE_WIDTH{1'b0}}, busy[i]};
            if (!busy[i])
                free_idx = RS_SIZE_WIDTH'(i);
        end
    end

    assign rs_full     = (busy_cnt == (RS_SIZE_WIDTH + 1)'(RS_SIZE));
    assign do_dispatch = dec_valid && !rs_full;
    assign rdy         = busy & ~pend1 & ~pend2;

    // Dispatch-time bypass; the ALU broadcast wins when both buses carry the same id.
    always_comb begin
        new_pend1 = dec_has_dep1;
        new_val1  = dec_val1;
        if (dec_has_dep1) begin
            if (alu_ready && alu_id == dec_dep1) begin
                new_pend1 = 1'b0;
                new_val1  = alu_res;
            end else if (lsb_ready && lsb_id == dec_dep1) begin
                new_pend1 = 1'b0;
                new_val1  = lsb_res;
            end
        end
        new_pend2 = dec_has_dep2;
        new_val2  = dec_val2;
        if (dec_has_dep2) begin
            if (alu_ready && alu_id == dec_dep2) begin
                new_pend2 = 1'b0;
                new_val2  = alu_res;
            end else if (lsb_ready && lsb_id == dec_dep2) begin
                new_pend2 = 1'b0;
                new_val2  = lsb_res;
            end
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    // older[j][i] set means entry j was dispatched before entry i.
    logic [RS_SIZE-1:0] older [RS_SIZE];
    logic [RS_SIZE-1:0] blocked;

    always_ff @(posedge clk) begin
        if (do_dispatch) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                older[free_idx][j] <= 1'b0;
                if (j != int'(free_idx))
                    older[j][free_idx] <= 1'b1;
            end
        end
    end

    always_comb begin
        blocked   = '0;
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                if (j != i && rdy[j] && older[j][i])
                    blocked[i] = 1'b1;
            end
            if (rdy[i] && !blocked[i] && !sel_valid) begin
                sel_valid = 1'b1;
                sel_idx   = RS_SIZE_WIDTH'(i);
            end
        end
    end
`else
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (rdy[i]) begin
                sel_valid = 1'b1;
                sel_idx   = RS_SIZE_WIDTH'(i);
            end
        end
    end
`endif

    always_comb begin
        busy_nxt = busy;
        if (sel_valid)
            busy_nxt[sel_idx] = 1'b0;
        if (do_dispatch)
            busy_nxt[free_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            rs_ready <= 1'b0;
            rs_op    <= '0;
            rs_val1  <= '0;
            rs_val2  <= '0;
            rs_id    <= '0;
        end else if (flush) begin
            busy     <= '0;
            rs_ready <= 1'b0;
            rs_op    <= '0;
            rs_val1  <= '0;
            rs_val2  <= '0;
            rs_id    <= '0;
        end else begin
            busy     <= busy_nxt;
            rs_ready <= sel_valid;
            rs_op    <= sel_valid ? op_q[sel_idx]   : '0;
            rs_val1  <= sel_valid ? val1_q[sel_idx] : '0;
            rs_val2  <= sel_valid ? val2_q[sel_idx] : '0;
            rs_id    <= sel_valid ? id_q[sel_idx]   : '0;
        end
    end

    // Payload carries no reset: busy alone decides whether an entry is meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (do_dispatch && int'(free_idx) == i) begin
                op_q[i]   <= dec_op;
                id_q[i]   <= dec_id;
                dep1_q[i] <= dec_dep1;
                dep2_q[i] <= dec_dep2;
                pend1[i]  <= new_pend1;
                pend2[i]  <= new_pend2;
                val1_q[i] <= new_val1;
                val2_q[i] <= new_val2;
            end else begin
                if (pend1[i]) begin
                    if (alu_ready && alu_id == dep1_q[i]) begin
                        pend1[i]  <= 1'b0;
                        val1_q[i] <= alu_res;
                    end else if (lsb_ready && lsb_id == dep1_q[i]) begin
                        pend1[i]  <= 1'b0;
                        val1_q[i] <= lsb_res;
                    end
                end
                if (pend2[i]) begin
                    if (alu_ready && alu_id == dep2_q[i]) begin
                        pend2[i]  <= 1'b0;
                        val2_q[i] <= alu_res;
                    end else if (lsb_ready && lsb_id == dep2_q[i]) begin
                        pend2[i]  <= 1'b0;
                        val2_q[i] <= lsb_res;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// tb/tb_rs_alu.sv - directed self-checking bench for rs_alu.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module tb_rs_alu;

    localparam logic [`ALU_OP_WIDTH-1:0] ALU_ADD = 1;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       flush;
    logic                       dec_valid;
    logic [`ALU_OP_WIDTH-1:0]   dec_op;
    logic [`ROB_SIZE_WIDTH-1:0] dec_id;
    logic                       dec_has_dep1;
    logic                       dec_has_dep2;
    logic [`ROB_SIZE_WIDTH-1:0] dec_dep1;
    logic [`ROB_SIZE_WIDTH-1:0] dec_dep2;
    logic [`XLEN-1:0]           dec_val1;
    logic [`XLEN-1:0]           dec_val2;
    logic                       alu_ready;
    logic [`XLEN-1:0]           alu_res;
    logic [`ROB_SIZE_WIDTH-1:0] alu_id;
    logic                       lsb_ready;
    logic [`XLEN-1:0]           lsb_res;
    logic [`ROB_SIZE_WIDTH-1:0] lsb_id;
    logic                       rs_full;
    logic                       rs_ready;
    logic [`ALU_OP_WIDTH-1:0]   rs_op;
    logic [`XLEN-1:0]           rs_val1;
    logic [`XLEN-1:0]           rs_val2;
    logic [`ROB_SIZE_WIDTH-1:0] rs_id;

    int checks = 0;
    int errors = 0;

    rs_alu #(.RS_SIZE_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .dec_valid(dec_valid), .dec_op(dec_op), .dec_id(dec_id),
        .dec_has_dep1(dec_has_dep1), .dec_has_dep2(dec_has_dep2),
        .dec_dep1(dec_dep1), .dec_dep2(dec_dep2),
        .dec_val1(dec_val1), .dec_val2(dec_val2),
        .alu_ready(alu_ready), .alu_res(alu_res), .alu_id(alu_id),
        .lsb_ready(lsb_ready), .lsb_res(lsb_res), .lsb_id(lsb_id),
        .rs_full(rs_full), .rs_ready(rs_ready), .rs_op(rs_op),
        .rs_val1(rs_val1), .rs_val2(rs_val2), .rs_id(rs_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rdy, input logic [63:0] op,
                           input logic [63:0] v1, input logic [63:0] v2, input logic [63:0] id);
        chk({tag, ".ready"}, 64'(rs_ready), 64'(rdy));
        chk({tag, ".op"},    64'(rs_op),    op);
        chk({tag, ".val1"},  64'(rs_val1),  v1);
        chk({tag, ".val2"},  64'(rs_val2),  v2);
        chk({tag, ".id"},    64'(rs_id),    id);
    endtask

    task automatic clr();
        dec_valid = 0; dec_op = '0; dec_id = '0;
        dec_has_dep1 = 0; dec_has_dep2 = 0; dec_dep1 = '0; dec_dep2 = '0;
        dec_val1 = '0; dec_val2 = '0;
        alu_ready = 0; alu_res = '0; alu_id = '0;
        lsb_ready = 0; lsb_res = '0; lsb_id = '0;
    endtask

    task automatic disp(input int op, input int id, input bit hd1, input int d1, input int v1,
                        input bit hd2, input int d2, input int v2);
        dec_valid = 1; dec_op = `ALU_OP_WIDTH'(op); dec_id = `ROB_SIZE_WIDTH'(id);
        dec_has_dep1 = hd1; dec_dep1 = `ROB_SIZE_WIDTH'(d1); dec_val1 = `XLEN'(v1);
        dec_has_dep2 = hd2; dec_dep2 = `ROB_SIZE_WIDTH'(d2); dec_val2 = `XLEN'(v2);
    endtask

    task automatic alu_bc(input int id, input int res);
        alu_ready = 1; alu_id = `ROB_SIZE_WIDTH'(id); alu_res = `XLEN'(res);
    endtask

    task automatic lsb_bc(input int id, input int res);
        lsb_ready = 1; lsb_id = `ROB_SIZE_WIDTH'(id); lsb_res = `XLEN'(res);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        flush = 0;
        rst_n = 0;
        #12;
        chk_out("reset", 0, 0, 0, 0, 0);
        chk("reset.full", 64'(rs_full), 0);
        rst_n = 1;

        // Reset asserted while one entry is issuing and another waits.
        disp(ALU_ADD, 1, 0, 0, 1, 0, 0, 2);
        tick();
        disp(ALU_ADD, 2, 0, 0, 3, 0, 0, 4);
        tick();
        clr();
        chk_out("midrst.pre", 1, ALU_ADD, 1, 2, 1);
        rst_n = 0;
        #1;
        chk_out("midrst.async", 0, 0, 0, 0, 0);
        chk("midrst.full", 64'(rs_full), 0);
        #2;
        rst_n = 1;
        tick();
        chk("midrst.post1", 64'(rs_ready), 0);
        tick();
        chk("midrst.post2", 64'(rs_ready), 0);

        // No-dependency dispatch: one-cycle latency then idle.
        disp(ALU_ADD, 3, 0, 0, 5, 0, 0, 7);
        tick();
        clr();
        chk("nodep.e0", 64'(rs_ready), 0);
        tick();
        chk_out("nodep.e1", 1, ALU_ADD, 5, 7, 3);
        tick();
        chk_out("nodep.e2", 0, 0, 0, 0, 0);

        // Wakeup via ALU broadcast.
        disp(2, 4, 1, 2, 0, 0, 0, 9);
        tick();
        clr();
        tick();
        chk("wake.wait", 64'(rs_ready), 0);
        alu_bc(2, 'h10);
        tick();
        clr();
        chk("wake.lat", 64'(rs_ready), 0);
        tick();
        chk_out("wake.issue", 1, 2, 'h10, 9, 4);

        // Dispatch bypass from LSB broadcast.
        disp(3, 5, 0, 0, 1, 1, 6, 0);
        lsb_bc(6, 'hAB);
        tick();
        clr();
        tick();
        chk_out("bypass", 1, 3, 1, 'hAB, 5);

        // ALU broadcast wins over LSB with the same id.
        disp(4, 7, 1, 3, 0, 0, 0, 8);
        alu_bc(3, 'h22);
        lsb_bc(3, 'h33);
        tick();
        clr();
        tick();
        chk_out("prio", 1, 4, 'h22, 8, 7);
        tick();
        chk("prio.idle", 64'(rs_ready), 0);

        // Fill all eight slots with dependent entries.
        for (int i = 0; i < 8; i++) begin
            disp(ALU_ADD, i, 1, 8 + i, 0, 0, 0, i);
            tick();
        end
        clr();
        chk("full.set", 64'(rs_full), 1);
        disp(ALU_ADD, 9, 0, 0, 'h99, 0, 0, 'h99);
        tick();
        clr();
        chk("full.hold", 64'(rs_full), 1);
        tick();
        chk("full.drop", 64'(rs_ready), 0);
        alu_bc(10, 'h55);
        tick();
        clr();
        chk("full.wake", 64'(rs_full), 1);
        chk("full.wake_rdy", 64'(rs_ready), 0);
        tick();
        chk_out("full.issue", 1, ALU_ADD, 'h55, 2, 2);
        chk("full.fall", 64'(rs_full), 0);
        flush = 1;
        tick();
        flush = 0;
        chk("full.flush", 64'(rs_full), 0);

        // Flush with three busy entries and a simultaneous dispatch.
        for (int i = 1; i <= 3; i++) begin
            disp(ALU_ADD, i, 1, 11 + i, 0, 0, 0, 0);
            tick();
        end
        clr();
        flush = 1;
        disp(ALU_ADD, 6, 0, 0, 1, 0, 0, 1);
        tick();
        flush = 0;
        clr();
        chk_out("flush", 0, 0, 0, 0, 0);
        chk("flush.full", 64'(rs_full), 0);
        alu_bc(12, 1);
        lsb_bc(13, 2);
        tick();
        clr();
        alu_bc(14, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            clr();
            chk("flush.quiet", 64'(rs_ready), 0);
        end

        // Age order: slot 5 older than a re-dispatched slot 1.
        for (int i = 0; i < 6; i++) begin
            disp(ALU_ADD, i, 1, 8 + i, 0, 0, 0, 0);
            tick();
        end
        clr();
        alu_bc(9, 'h61);
        tick();
        clr();
        tick();
        chk_out("age.free1", 1, ALU_ADD, 'h61, 0, 1);
        disp(ALU_ADD, 11, 1, 14, 0, 0, 0, 0);
        tick();
        clr();
        alu_bc(13, 'h75);
        lsb_bc(14, 'h7E);
        tick();
        clr();
        tick();
`ifdef RS_OLDEST_FIRST_EN
        chk_out("age.first", 1, ALU_ADD, 'h75, 0, 5);
        tick();
        chk_out("age.second", 1, ALU_ADD, 'h7E, 0, 11);
`else
        chk_out("age.first", 1, ALU_ADD, 'h7E, 0, 11);
        tick();
        chk_out("age.second", 1, ALU_ADD, 'h75, 0, 5);
`endif
        tick();
        chk("age.idle", 64'(rs_ready), 0);
        flush = 1;
        tick();
        flush = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
